button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Receive-side front end for a DE-10 Lite pushbutton: synchronises, debounces and decodes the raw KEY input into a clean level plus press, release, long-press and toggle events.
- Sits between the board pins and control logic (mode select, LED indication, RC-car enable).
- Downstream logic no longer samples raw buttons.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles input must be stable to accept a change (10 ms at 50 MHz); minimum 2
LONG_CYCLES, 50000000, cycles held, counted from press acceptance, before long_press fires (1 s at 50 MHz); must exceed DEBOUNCE_CYCLES
ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed (DE-10 Lite KEY); 0 = active-high

Ports:
clk  input  1  system clock, 50 MHz, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
btn  input  1  raw asynchronous button pin, polarity per ACTIVE_LOW
btn_level  output  1  debounced level, 1 = pressed
press_pulse  output  1  one-cycle strobe on accepted press
release_pulse  output  1  one-cycle strobe on accepted release
long_press  output  1  one-cycle strobe when hold reaches LONG_CYCLES
toggle  output  1  flips on every accepted press

Behaviour:
- Reset: one clock (clk); rst_n is asynchronous, active-low. While rst_n = 0:
  - FSM = IDLE; all counters = 0.
  - All outputs = 0.
  - Both synchroniser flops = inactive raw value (1 if ACTIVE_LOW, else 0).
- Synchroniser: two-flop chain on btn. Normalised signal btn_s = sync2 XOR ACTIVE_LOW, so 1 = pressed. FSM uses only btn_s.
- Debounce counter: width clog2(DEBOUNCE_CYCLES). Hold counter: width clog2(LONG_CYCLES). Both are registered, with no wrap.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE:
    - btn_s = 1 -> PRESS_WAIT, deb_cnt <= 0.
  - PRESS_WAIT:
    - btn_s = 0 -> IDLE (glitch rejected, no outputs).
    - Else if deb_cnt = DEBOUNCE_CYCLES-1 -> PRESSED; btn_level <= 1, press_pulse <= 1 for one cycle, toggle <= ~toggle, hold_cnt <= 0.
    - Else deb_cnt++.
  - PRESSED:
    - hold_cnt increments while below LONG_CYCLES-1.
    - On the transition to LONG_CYCLES-1, long_press <= 1 for one cycle. hold_cnt then saturates, so at most one long_press per press.
    - btn_s = 0 -> RELEASE_WAIT, deb_cnt <= 0.
  - RELEASE_WAIT:
    - hold_cnt keeps advancing and saturating as in PRESSED; long_press may fire here.
    - btn_s = 1 -> PRESSED (bounce rejected; no pulse; hold_cnt not cleared).
    - Else if deb_cnt = DEBOUNCE_CYCLES-1 -> IDLE; btn_level <= 0, release_pulse <= 1 for one cycle, hold_cnt <= 0.
    - Else deb_cnt++.
- Latency: take edge 0 as the first clk edge at which sync1 captures the active btn, with btn stable afterwards.
  - PRESS_WAIT entered at edge 2.
  - press_pulse, btn_level and toggle update at edge DEBOUNCE_CYCLES+2.
  - Release is symmetric: release_pulse and btn_level=0 at edge DEBOUNCE_CYCLES+2 after release is first sampled.
- long_press is registered at the edge that is LONG_CYCLES-1 cycles after press_pulse asserts.
- Pulse outputs are registered and never high in consecutive cycles from the same event. press_pulse and release_pulse are mutually exclusive.
- Button released before LONG_CYCLES is reached: no long_press.
- Bounces shorter than DEBOUNCE_CYCLES in either direction produce no output change.
- Reset mid-operation (any state): all outputs clear immediately and asynchronously. After rst_n rises, a held button is detected as a fresh press after the full latency. No release_pulse is emitted for the aborted press.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
1. Reset with btn=1, then btn held at 1 for 50 cycles -> all outputs 0 throughout, FSM stays IDLE.
2. Drive btn=0 from edge 0 and hold 10 cycles -> press_pulse high exactly at edge 6 for one cycle, btn_level=1 from edge 6, toggle 0->1. Then btn=1 -> release_pulse one cycle, 6 edges after release is first sampled, btn_level=0.
3. btn=0 pulses of 1, 2 and 3 cycles separated by 10 cycles of btn=1 -> no press_pulse, btn_level stays 0, toggle unchanged.
4. Press held 40 cycles -> long_press one cycle exactly 19 cycles after press_pulse, never again during the hold. Released after 10 cycles -> no long_press.
5. While pressed, inject 2-cycle btn=1 bounce -> no release_pulse, btn_level stays 1, hold_cnt not reset (long_press timing unchanged).
6. Three full press/release cycles -> toggle sequence 1,0,1. Assert rst_n=0 mid-hold -> outputs 0 immediately; release rst_n with btn held -> press_pulse 6 edges after the first sampling edge following reset release, no release_pulse before it.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: pushbutton front end. Synchronises the raw pin,
// debounces it in both directions and decodes a clean level plus press,
// release, long-press and toggle events.
//
// Ports:
//   clk           in   system clock, all logic on the rising edge
//   rst_n         in   asynchronous active-low reset
//   btn           in   raw asynchronous button pin (polarity per ACTIVE_LOW)
//   btn_level     out  debounced level, 1 = pressed
//   press_pulse   out  one-cycle strobe on accepted press
//   release_pulse out  one-cycle strobe on accepted release
//   long_press    out  one-cycle strobe when the hold reaches LONG_CYCLES
//   toggle        out  flips on every accepted press
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic toggle
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              toggle_q, toggle_d;
  logic              btn_s;

  // Two-flop synchroniser; resets to the idle (not pressed) pin value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Normalised: 1 = pressed regardless of board polarity.
  assign btn_s = sync2_q ^ ACTIVE_LOW;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      toggle_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      toggle_q   <= toggle_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    toggle_d   = toggle_q;

    // Hold timer runs through release bounces; saturation limits long_press
    // to one strobe per press.
    if ((state_q == PRESSED) || (state_q == RELEASE_WAIT)) begin
      if (hold_cnt_q < HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        long_d     = (hold_cnt_q == HOLD_FIRE);
      end
    end

    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = PRESSED;
          level_d    = 1'b1;
          press_d    = 1'b1;
          toggle_d   = ~toggle_q;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = PRESSED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = IDLE;
          level_d    = 1'b0;
          release_d  = 1'b1;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign toggle        = toggle_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// LONG_CYCLES=20, ACTIVE_LOW=1. Edge k counts from the first edge at which
// the synchroniser samples a new btn value.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic btn_level, press_pulse, release_pulse, long_press, toggle;

  int n_assert = 0;
  int n_fail   = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .toggle       (toggle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".level"},   btn_level,     1'b0);
    chk({tag, ".press"},   press_pulse,   1'b0);
    chk({tag, ".release"}, release_pulse, 1'b0);
    chk({tag, ".long"},    long_press,    1'b0);
    chk({tag, ".toggle"},  toggle,        1'b0);
  endtask

  // Press for hold edges then release for 10 edges; checks press/release
  // timing and the toggle value after the press.
  task automatic press_release(input string tag, input int hold, input logic tog_exp);
    btn = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({tag, ".press"}, press_pulse, 1'(k == 6));
      chk({tag, ".level"}, btn_level,   1'(k >= 6));
    end
    chk({tag, ".toggle"}, toggle, tog_exp);
    btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk({tag, ".release"}, release_pulse, 1'(k == 6));
      chk({tag, ".rlevel"},  btn_level,     1'(k < 6));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    btn   = 1'b1;
    #2;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: idle button, nothing happens.
    for (int k = 0; k < 50; k++) begin
      tick();
      chk_all_zero("idle");
    end

    // 2: basic press and release.
    btn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t2.press",  press_pulse,   1'(k == 6));
      chk("t2.level",  btn_level,     1'(k >= 6));
      chk("t2.toggle", toggle,        1'(k >= 6));
      chk("t2.rel0",   release_pulse, 1'b0);
    end
    btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t2.release", release_pulse, 1'(k == 6));
      chk("t2.rlevel",  btn_level,     1'(k < 6));
      chk("t2.press0",  press_pulse,   1'b0);
    end

    // 3: short glitches of 1..3 cycles are rejected.
    for (int w = 1; w <= 3; w++) begin
      btn = 1'b0;
      for (int k = 0; k < w; k++) begin
        tick();
        chk("t3.press", press_pulse, 1'b0);
      end
      btn = 1'b1;
      for (int k = 0; k < 10; k++) begin
        tick();
        chk("t3.press",  press_pulse, 1'b0);
        chk("t3.level",  btn_level,   1'b0);
        chk("t3.toggle", toggle,      1'b1);
      end
    end

    // 4a: 40-cycle hold, long_press once at press+19.
    btn = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("t4.press", press_pulse, 1'(k == 6));
      chk("t4.long",  long_press,  1'(k == 25));
    end
    chk("t4.toggle", toggle, 1'b0);
    btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4.release", release_pulse, 1'(k == 6));
      chk("t4.long0",   long_press,    1'b0);
    end

    // 4b: 10-cycle hold, no long_press.
    btn = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 10) btn = 1'b1;
      tick();
      chk("t4b.press",   press_pulse,   1'(k == 6));
      chk("t4b.release", release_pulse, 1'(k == 16));
      chk("t4b.long",    long_press,    1'b0);
    end
    chk("t4b.toggle", toggle, 1'b1);

    // 5: 2-cycle release bounce mid-hold.
    btn = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("t5.press",   press_pulse,   1'(k == 6));
      chk("t5.level",   btn_level,     1'(k >= 6));
      chk("t5.release", release_pulse, 1'b0);
      chk("t5.long",    long_press,    1'(k == 25));
      btn = (k == 9 || k == 10) ? 1'b1 : 1'b0;
    end
    btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5.rel", release_pulse, 1'(k == 6));
    end
    chk("t5.toggle", toggle, 1'b0);

    // 6: toggle sequence 1,0,1.
    press_release("t6a", 10, 1'b1);
    press_release("t6b", 10, 1'b0);
    press_release("t6c", 10, 1'b1);

    // 6: reset mid-hold, then held button re-detected as a fresh press.
    btn = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("t6r.press", press_pulse, 1'(k == 6));
    end
    chk("t6r.level_before", btn_level, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6r.async");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("t6r.held");
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t6r.press2",  press_pulse,   1'(k == 6));
      chk("t6r.release", release_pulse, 1'b0);
      chk("t6r.level2",  btn_level,     1'(k >= 6));
      chk("t6r.toggle2", toggle,        1'(k >= 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
